// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: widths, FSM encoding,
// write payload and a register-index-to-mask helper.
package reg_write_arbiter_pkg;

    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned WAIT_CNT_W = 4;

    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = 4'hF;

    typedef enum logic {
        A_PRIO = 1'b0,
        B_PRIO = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] idx;
        logic [DATA_W-1:0]    data;
    } reg_wr_t;

    // One-hot mask selecting the flag of register idx
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_IDX_W-1:0] idx);
        reg_mask = NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_scoreboard.sv
// reg_scoreboard: one pending-write flag per register. A claim sets the flag on
// the next edge, a completed B write clears it; a same-edge claim wins over the
// clear. Register 0 never becomes pending.
module reg_scoreboard
    import reg_write_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 claim_valid,
    input  logic [REG_IDX_W-1:0] claim_reg,
    input  logic                 clear_valid,
    input  logic [REG_IDX_W-1:0] clear_reg,
    output logic [NUM_REGS-1:0]  busy
);

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // Decode claim and clear requests into per-register masks
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (claim_valid && (claim_reg != '0)) begin
            set_mask = reg_mask(claim_reg);
        end
        if (clear_valid) begin
            clr_mask = reg_mask(clear_reg);
        end
    end

    // Flag register: clear first, then set, bit 0 forced low
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: arbitrates the single register-file write port between the
// pipeline writeback (A, normally preferred) and a long-latency unit (B). B gains
// priority after losing MAX_WAIT consecutive cycles and keeps it until it writes.
// Optional build macro REG_WRITE_ARB_SCOREBOARD_EN adds the pending-write
// scoreboard driving busy; without it busy is tied to zero.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_valid,
    input  logic [REG_IDX_W-1:0] a_reg,
    input  logic [DATA_W-1:0]    a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [REG_IDX_W-1:0] b_reg,
    input  logic [DATA_W-1:0]    b_data,
    output logic                 b_ready,
    input  logic                 claim_valid,
    input  logic [REG_IDX_W-1:0] claim_reg,
    output logic                 reg_write,
    output logic [REG_IDX_W-1:0] reg_d,
    output logic [DATA_W-1:0]    d,
    output logic [NUM_REGS-1:0]  busy
);

    arb_state_e            state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt_nxt;
    logic                  a_hs;
    logic                  b_hs;
    reg_wr_t               win;

    // Ready signals follow the current priority holder
    always_comb begin
        a_ready = (state == A_PRIO) ? 1'b1 : !b_valid;
        b_ready = (state == B_PRIO) ? 1'b1 : !a_valid;
    end

    assign a_hs = a_valid & a_ready;
    assign b_hs = b_valid & b_ready;

    // Consecutive-loss counter for B, saturating, cleared when B writes
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (b_hs) begin
            wait_cnt_nxt = '0;
        end else if (b_valid && (wait_cnt != WAIT_CNT_MAX)) begin
            wait_cnt_nxt = wait_cnt + WAIT_CNT_W'(1);
        end
    end

    // Select the payload of whichever side completed its handshake
    always_comb begin
        win.idx  = b_reg;
        win.data = b_data;
        if (a_hs) begin
            win.idx  = a_reg;
            win.data = a_data;
        end
    end

    // Priority FSM and loss counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= A_PRIO;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            case (state)
                A_PRIO: if (wait_cnt_nxt >= WAIT_CNT_W'(MAX_WAIT)) state <= B_PRIO;
                B_PRIO: if (b_hs) state <= A_PRIO;
                default: state <= A_PRIO;
            endcase
        end
    end

    // Registered write port; writes to r0 are accepted but not emitted
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write <= 1'b0;
            reg_d     <= '0;
            d         <= '0;
        end else begin
            reg_write <= (a_hs | b_hs) && (win.idx != '0);
            if (a_hs | b_hs) begin
                reg_d <= win.idx;
                d     <= win.data;
            end
        end
    end

`ifdef REG_WRITE_ARB_SCOREBOARD_EN
    reg_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .claim_valid (claim_valid),
        .claim_reg   (claim_reg),
        .clear_valid (b_hs),
        .clear_reg   (b_reg),
        .busy        (busy)
    );
`else
    logic unused_claim;
    assign unused_claim = ^{claim_valid, claim_reg};
    assign busy         = '0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the priority rules.
module tb_reg_write_arbiter;

    localparam int unsigned MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, claim_valid;
    logic [4:0]  a_reg, b_reg, claim_reg;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        reg_write;
    logic [4:0]  reg_d;
    logic [31:0] d;
    logic [31:0] busy;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit          m_bprio;
    int          m_losses;
    logic [31:0] m_busy;

    // Expected and observed values for the most recent cycle
    logic        exp_a_ready, exp_b_ready, obs_a_ready, obs_b_ready;
    logic        exp_write;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;

    reg_write_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_reg       (a_reg),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_reg       (b_reg),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .claim_valid (claim_valid),
        .claim_reg   (claim_reg),
        .reg_write   (reg_write),
        .reg_d       (reg_d),
        .d           (d),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Drive one cycle, capture readies mid-cycle, advance the model, return at edge+1
    task automatic drive_cycle(input logic rs, input logic av, input logic [4:0] ar,
                               input logic [31:0] ad, input logic bv, input logic [4:0] br,
                               input logic [31:0] bd, input logic cv, input logic [4:0] cr);
        bit ha, hb;
        @(negedge clk);
        reset = rs; a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd; claim_valid = cv; claim_reg = cr;
        #1;
        obs_a_ready = a_ready;
        obs_b_ready = b_ready;
        exp_a_ready = !m_bprio || !bv;
        exp_b_ready = m_bprio || !av;
        ha = av && exp_a_ready;
        hb = bv && exp_b_ready;
        if (rs) begin
            m_bprio = 0; m_losses = 0; m_busy = '0;
            exp_write = 0; exp_reg = '0; exp_data = '0;
        end else begin
            if (ha) begin
                exp_write = (ar != 0); exp_reg = ar; exp_data = ad;
            end else if (hb) begin
                exp_write = (br != 0); exp_reg = br; exp_data = bd;
            end else begin
                exp_write = 0;
            end
            if (hb) m_losses = 0;
            else if (bv) m_losses = (m_losses + 1 > 15) ? 15 : m_losses + 1;
            if (!m_bprio && m_losses >= int'(MAX_WAIT)) m_bprio = 1;
            else if (m_bprio && hb) m_bprio = 0;
`ifdef REG_WRITE_ARB_SCOREBOARD_EN
            if (hb) m_busy[br] = 1'b0;
            if (cv && cr != 0) m_busy[cr] = 1'b1;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic rs);
        drive_cycle(rs, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
    endtask

    task automatic test_reset();
        // Reset while A is handshaking a write to r5: nothing may come out
        drive_cycle(1, 1, 5'd5, 32'hCAFE_0005, 0, 5'd0, 32'd0, 0, 5'd0);
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_write got %0b exp 0", reg_write); end
        checks++; if (reg_d !== 5'd0 || d !== 32'd0) begin errors++; $display("FAIL reset_regd got %0d/%h exp 0/0", reg_d, d); end
        checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy); end
        // Cycle after reset: A priority, B must wait while A is valid
        drive_cycle(0, 1, 5'd0, 32'd0, 1, 5'd1, 32'd0, 0, 5'd0);
        checks++; if (obs_a_ready !== 1'b1 || obs_b_ready !== 1'b0) begin
            errors++; $display("FAIL post_reset_ready got a=%0b b=%0b exp a=1 b=0", obs_a_ready, obs_b_ready);
        end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL post_reset_r0 got %0b exp 0", reg_write); end
        idle_cycle(1);
    endtask

    task automatic test_a_write();
        drive_cycle(0, 1, 5'd3, 32'hDEAD_BEEF, 0, 5'd0, 32'd0, 0, 5'd0);
        checks++; if (reg_write !== 1'b1 || reg_d !== 5'd3 || d !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL a_write got we=%0b rd=%0d d=%h exp we=1 rd=3 d=deadbeef", reg_write, reg_d, d);
        end
        idle_cycle(0);
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL a_write_pulse got %0b exp 0", reg_write); end
    endtask

    task automatic test_starvation();
        idle_cycle(1);
        for (int i = 0; i < int'(MAX_WAIT); i++) begin
            drive_cycle(0, 1, 5'd2, 32'h100 + 32'(i), 1, 5'd7, 32'h7777_0007, 0, 5'd0);
            checks++; if (obs_a_ready !== 1'b1 || obs_b_ready !== 1'b0 || reg_write !== 1'b1 || reg_d !== 5'd2 || d !== 32'h100 + 32'(i)) begin
                errors++; $display("FAIL starve_a%0d got ar=%0b br=%0b we=%0b rd=%0d d=%h exp 1 0 1 2 %h",
                                   i, obs_a_ready, obs_b_ready, reg_write, reg_d, d, 32'h100 + 32'(i));
            end
        end
        drive_cycle(0, 1, 5'd2, 32'h200, 1, 5'd7, 32'h7777_0007, 0, 5'd0);
        checks++; if (obs_a_ready !== 1'b0 || obs_b_ready !== 1'b1 || reg_write !== 1'b1 || reg_d !== 5'd7 || d !== 32'h7777_0007) begin
            errors++; $display("FAIL starve_b got ar=%0b br=%0b we=%0b rd=%0d d=%h exp 0 1 1 7 77770007",
                               obs_a_ready, obs_b_ready, reg_write, reg_d, d);
        end
        drive_cycle(0, 1, 5'd2, 32'h300, 1, 5'd7, 32'h7777_0007, 0, 5'd0);
        checks++; if (obs_a_ready !== 1'b1 || obs_b_ready !== 1'b0 || reg_d !== 5'd2) begin
            errors++; $display("FAIL starve_back got ar=%0b br=%0b rd=%0d exp 1 0 2", obs_a_ready, obs_b_ready, reg_d);
        end
        // Re-enter B priority, then B idles: A is granted and B priority is kept
        idle_cycle(1);
        for (int i = 0; i < int'(MAX_WAIT); i++) drive_cycle(0, 1, 5'd4, 32'h4, 1, 5'd8, 32'h8, 0, 5'd0);
        drive_cycle(0, 1, 5'd6, 32'h666, 0, 5'd8, 32'h8, 0, 5'd0);
        checks++; if (obs_a_ready !== 1'b1 || obs_b_ready !== 1'b1 || reg_write !== 1'b1 || reg_d !== 5'd6) begin
            errors++; $display("FAIL bprio_idle got ar=%0b br=%0b we=%0b rd=%0d exp 1 1 1 6", obs_a_ready, obs_b_ready, reg_write, reg_d);
        end
        drive_cycle(0, 1, 5'd6, 32'h667, 1, 5'd8, 32'h888, 0, 5'd0);
        checks++; if (obs_a_ready !== 1'b0 || obs_b_ready !== 1'b1 || reg_d !== 5'd8 || d !== 32'h888) begin
            errors++; $display("FAIL bprio_kept got ar=%0b br=%0b rd=%0d d=%h exp 0 1 8 888", obs_a_ready, obs_b_ready, reg_d, d);
        end
    endtask

    task automatic test_r0_drop();
        idle_cycle(1);
        drive_cycle(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h1, 0, 5'd0);
        checks++; if (obs_b_ready !== 1'b1 || reg_write !== 1'b0) begin
            errors++; $display("FAIL r0_drop got br=%0b we=%0b exp br=1 we=0", obs_b_ready, reg_write);
        end
    endtask

    task automatic test_scoreboard();
        logic [31:0] want;
        idle_cycle(1);
        drive_cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9);
`ifdef REG_WRITE_ARB_SCOREBOARD_EN
        want = 32'h200;
`else
        want = 32'h0;
`endif
        checks++; if (busy !== want) begin errors++; $display("FAIL sb_claim got %h exp %h", busy, want); end
        idle_cycle(0);
        checks++; if (busy !== want) begin errors++; $display("FAIL sb_hold got %h exp %h", busy, want); end
        drive_cycle(0, 0, 5'd0, 32'd0, 1, 5'd9, 32'h9, 0, 5'd0);
        checks++; if (busy !== 32'h0) begin errors++; $display("FAIL sb_clear got %h exp 0", busy); end
        drive_cycle(0, 0, 5'd0, 32'd0, 1, 5'd9, 32'h9, 1, 5'd9);
        checks++; if (busy !== want) begin errors++; $display("FAIL sb_same_edge got %h exp %h", busy, want); end
        drive_cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd0);
        checks++; if (busy !== want) begin errors++; $display("FAIL sb_r0_claim got %h exp %h", busy, want); end
        drive_cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd4);
        checks++; if (busy !== m_busy) begin errors++; $display("FAIL sb_claim4 got %h exp %h", busy, m_busy); end
    endtask

    task automatic test_random();
        logic rs, av, bv, cv;
        logic [4:0] ar, br, cr;
        idle_cycle(1);
        for (int n = 0; n < 400; n++) begin
            rs = ($urandom_range(0, 39) == 0);
            av = ($urandom_range(0, 3) != 0);
            bv = ($urandom_range(0, 2) != 0);
            cv = ($urandom_range(0, 2) == 0);
            ar = 5'($urandom_range(0, 31));
            br = 5'($urandom_range(0, 31));
            cr = 5'($urandom_range(0, 31));
            drive_cycle(rs, av, ar, $urandom, bv, br, $urandom, cv, cr);
            checks++; if (obs_a_ready !== exp_a_ready || obs_b_ready !== exp_b_ready) begin
                errors++; $display("FAIL rand_ready n=%0d got a=%0b b=%0b exp a=%0b b=%0b", n, obs_a_ready, obs_b_ready, exp_a_ready, exp_b_ready);
            end
            checks++; if (reg_write !== exp_write || (exp_write && (reg_d !== exp_reg || d !== exp_data))) begin
                errors++; $display("FAIL rand_write n=%0d got we=%0b rd=%0d d=%h exp we=%0b rd=%0d d=%h",
                                   n, reg_write, reg_d, d, exp_write, exp_reg, exp_data);
            end
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand_busy n=%0d got %h exp %h", n, busy, m_busy); end
        end
    endtask

    initial begin
        reset = 1'b1; a_valid = 0; b_valid = 0; claim_valid = 0;
        a_reg = '0; b_reg = '0; claim_reg = '0; a_data = '0; b_data = '0;
        m_bprio = 0; m_losses = 0; m_busy = '0;
        exp_write = 0; exp_reg = '0; exp_data = '0;
        test_reset();
        test_a_write();
        test_starvation();
        test_r0_drop();
        test_scoreboard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, max consecutive cycles port B may lose before it takes priority (range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports a_valid input 1, a_reg input 5, a_data input 32, a_ready output 1  for the priority requester (pipeline writeback).
REQ-005 SHALL have ports b_valid input 1, b_reg input 5, b_data input 32, b_ready output 1  for the long-latency requester (load/mul-div unit).
REQ-006 SHALL have ports claim_valid input 1, claim_reg input 5  for the B-unit issue notice, which marks a register as pending.
REQ-007 SHALL have ports reg_write output 1, reg_d output 5, d output 32  driving the register-file write port.
REQ-008 SHALL have port busy  output 32  with one pending-write flag per register.

Function
REQ-009 SHALL complete a handshake on a port when its valid and ready are both high on a clock edge.
REQ-010 SHALL register the winning write: reg_write/reg_d/d SHALL reflect the handshake one cycle later and stay valid for exactly one cycle.
REQ-011 SHALL implement FSM states A_PRIO (reset state) and B_PRIO.
REQ-012 In A_PRIO: a_ready=1; b_ready = !a_valid.
REQ-013 In B_PRIO: b_ready=1; a_ready = !b_valid.
REQ-014 SHALL keep a 4-bit wait counter: it increments when b_valid && !b_ready, and clears on a B handshake.
REQ-015 SHALL go A_PRIO->B_PRIO on the edge where the counter reaches MAX_WAIT, and B_PRIO->A_PRIO on the edge of the next B handshake.
REQ-016 In B_PRIO with b_valid low, SHALL grant A and stay in B_PRIO.
REQ-017 A handshake with reg index 0 SHALL be accepted, with reg_write held 0 the following cycle (r0 write dropped).
REQ-018 The counter SHALL saturate at 15 and never wrap.

Reset
REQ-019 On reset: state=A_PRIO, counter=0, reg_write=0, reg_d=0, d=0, busy=0.
REQ-020 Reset SHALL override a handshake in the same cycle: that write is discarded, never emitted.
REQ-021 a_ready and b_ready SHALL evaluate combinationally from the reset state values in the cycle after reset.

Configuration
REQ-022 Macro REG_WRITE_ARB_SCOREBOARD_EN SHALL compile in the busy scoreboard.
REQ-023 With the macro defined, claim_valid with claim_reg!=0 SHALL set busy[claim_reg] on the next edge.
REQ-024 With the macro defined, a B handshake SHALL clear busy[b_reg] on the same edge.
REQ-025 With the macro defined, a same-edge claim and clear of the same register SHALL leave the bit set.
REQ-026 With the macro defined, busy[0] SHALL always read 0.
REQ-027 Without the macro, busy SHALL be constant 0, claim inputs SHALL be ignored, and no scoreboard flops SHALL be inferred.

Structure
REQ-028 A shared package/header SHALL hold the state encodings (A_PRIO=0, B_PRIO=1), the register-index width 5 and the data width 32.
REQ-029 The scoreboard SHALL be a sub-module reg_scoreboard, instantiated only under REG_WRITE_ARB_SCOREBOARD_EN.
REQ-030 Arbiter FSM and output register SHALL stay in reg_write_arbiter.

Verification
REQ-031 Scenario: a_valid=1 a_reg=3 a_data=0xDEADBEEF, b idle -> next cycle reg_write=1, reg_d=3, d=0xDEADBEEF; cycle after, reg_write=0.
REQ-032 Scenario: a_valid and b_valid held high (b_reg=7), MAX_WAIT=4 -> A wins 4 cycles, then B_PRIO, b_ready=1, A stalled; reg_d=7 emitted; FSM returns to A_PRIO.
REQ-033 Scenario: b_valid=1 b_reg=0 b_data=0x1 -> handshake completes, reg_write stays 0.
REQ-034 Scenario (macro on): claim_reg=9, then later B write reg 9 -> busy=0x200 until the write edge, then 0; claim and write of reg 9 on the same edge -> bit stays set.
REQ-035 Scenario: reset asserted during an A handshake (a_reg=5) -> no write emitted, busy=0, state A_PRIO.
REQ-036 Scenario (macro off): claim_valid=1 claim_reg=4 -> busy remains 0x00000000.
